// File: rtl/des_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_pkg                                                                  |
// | Shared DES tables and helpers for the key schedule and datapath.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package des_pkg;

    typedef logic [27:0] half_key_t;

    localparam int SHIFT_TABLE [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // DES numbers bits from 1 at the MSB, so table entry n selects vector bit (width - n).
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = key[6'(64 - PC1_TABLE[i])];
        end
        return r;
    endfunction

    function automatic half_key_t rotl(input half_key_t x, input int s);
        return (s == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic half_key_t rotr(input half_key_t x, input int s);
        return (s == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_pc2                                                                  |
// | Combinational DES Permuted Choice 2, {C,D} 56 bits -> 48-bit subkey.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] i_cd,
    output logic [47:0] o_subkey
);

    genvar i;
    generate
        for (i = 0; i < 48; i++) begin : g_bit
            assign o_subkey[47 - i] = i_cd[56 - PC2_TABLE[i]];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_key_schedule                                                         |
// | Sequential DES key schedule: one 48-bit subkey per handshake, enc/dec.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module des_key_schedule
    import des_pkg::*;
#(
    parameter int PARITY_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        last_round,
    output logic        parity_err
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic        r_state;
    half_key_t   r_c;
    half_key_t   r_d;
    logic [3:0]  r_round_idx;
    logic        r_dir;
    logic        r_parity_err;

    logic [55:0] w_pc1;
    logic [3:0]  w_enc_sel;
    logic [3:0]  w_dec_sel;
    half_key_t   w_c_next;
    half_key_t   w_d_next;
    logic        w_parity_bad;

    assign w_pc1     = pc1(key_in);
    assign w_enc_sel = r_round_idx + 4'd1;
    assign w_dec_sel = 4'd15 - r_round_idx;

    // Decrypt walks the schedule backwards, undoing the shifts in reverse order.
    always_comb begin
        w_c_next = r_c;
        w_d_next = r_d;
        if (r_dir) begin
            w_c_next = rotr(r_c, SHIFT_TABLE[w_dec_sel]);
            w_d_next = rotr(r_d, SHIFT_TABLE[w_dec_sel]);
        end else begin
            w_c_next = rotl(r_c, SHIFT_TABLE[w_enc_sel]);
            w_d_next = rotl(r_d, SHIFT_TABLE[w_enc_sel]);
        end
    end

    generate
        if (PARITY_CHECK != 0) begin : g_parity
            always_comb begin
                w_parity_bad = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    if (~^key_in[b*8 +: 8]) begin
                        w_parity_bad = 1'b1;
                    end
                end
            end
        end else begin : g_no_parity
            assign w_parity_bad = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_c          <= '0;
            r_d          <= '0;
            r_round_idx  <= 4'd0;
            r_dir        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (key_valid) begin
                        // C16/D16 equal C0/D0, so decrypt starts from the unrotated halves.
                        if (decrypt) begin
                            r_c <= w_pc1[55:28];
                            r_d <= w_pc1[27:0];
                        end else begin
                            r_c <= rotl(w_pc1[55:28], 1);
                            r_d <= rotl(w_pc1[27:0], 1);
                        end
                        r_round_idx  <= 4'd0;
                        r_dir        <= decrypt;
                        r_parity_err <= w_parity_bad;
                        r_state      <= S_RUN;
                    end
                end
                default: begin
                    if (subkey_ready) begin
                        if (r_round_idx == 4'd15) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_c         <= w_c_next;
                            r_d         <= w_d_next;
                            r_round_idx <= r_round_idx + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    des_pc2 u_pc2 (
        .i_cd     ({r_c, r_d}),
        .o_subkey (subkey)
    );

    assign key_ready    = (r_state == S_IDLE);
    assign subkey_valid = (r_state == S_RUN);
    assign round_idx    = r_round_idx;
    assign last_round   = (r_state == S_RUN) && (r_round_idx == 4'd15);
    assign parity_err   = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_des_key_schedule                                                      |
// | Randomised bench for des_key_schedule against a textbook DES key model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_des_key_schedule;

    localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] key_in = '0;
    logic        decrypt = 1'b0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready = 1'b0;
    logic [3:0]  round_idx;
    logic        last_round;
    logic        parity_err;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [47:0] exp_seq [16];
    logic        exp_perr;
    logic [47:0] cap_first;
    logic [47:0] cap_last;
    logic [63:0] kat_key = 64'h133457799BBCDFF1;

    des_key_schedule #(.PARITY_CHECK(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .last_round   (last_round),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Subkey Kn from scratch: PC-1, cumulative left rotation of each half, then PC-2.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int n);
        logic        kb [1:64];
        logic        cd [1:56];
        logic        cn [1:56];
        logic [63:0] t;
        logic [47:0] sk;
        int          tot;
        t = k;
        for (int p = 1; p <= 64; p++) begin
            kb[p] = t[63];
            t = t << 1;
        end
        for (int j = 1; j <= 56; j++) cd[j] = kb[M_PC1[j-1]];
        tot = 0;
        for (int i = 0; i < n; i++) tot += M_SHIFT[i];
        for (int j = 1; j <= 28; j++) begin
            cn[j]      = cd[((j - 1 + tot) % 28) + 1];
            cn[j + 28] = cd[((j - 1 + tot) % 28) + 29];
        end
        sk = '0;
        for (int i = 0; i < 48; i++) sk = {sk[46:0], cn[M_PC2[i]]};
        return sk;
    endfunction

    function automatic logic ref_perr(input logic [63:0] k);
        for (int b = 0; b < 8; b++) begin
            if ($countones(k[b*8 +: 8]) % 2 == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic build(input logic [63:0] k, input logic dec);
        for (int r = 0; r < 16; r++) exp_seq[r] = dec ? ref_subkey(k, 16 - r) : ref_subkey(k, r + 1);
        exp_perr = ref_perr(k);
    endtask

    // Called at a negedge just after the accepting edge; returns at the negedge after the
    // final handshake, or early at position stop_at without handshaking it.
    task automatic drain(input int duty, input int stop_at);
        int got = 0;
        int cyc = 0;
        while (got < 16 && cyc < 500) begin
            chk("valid", {63'd0, subkey_valid}, 64'd1);
            chk("busy_ready", {63'd0, key_ready}, 64'd0);
            chk("subkey", {16'd0, subkey}, {16'd0, exp_seq[got]});
            chk("round_idx", {60'd0, round_idx}, 64'(got));
            chk("last_round", {63'd0, last_round}, {63'd0, got == 15});
            chk("parity_err", {63'd0, parity_err}, {63'd0, exp_perr});
            if (got == stop_at) return;
            subkey_ready = ($urandom_range(99) < duty);
            if (subkey_ready) begin
                if (got == 0) cap_first = subkey;
                if (got == 15) cap_last = subkey;
                got++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("drain_done", 64'(got), 64'd16);
        subkey_ready = 1'b0;
        chk("end_valid", {63'd0, subkey_valid}, 64'd0);
        chk("end_ready", {63'd0, key_ready}, 64'd1);
    endtask

    task automatic start(input logic [63:0] k, input logic dec);
        @(negedge clk);
        chk("idle_ready", {63'd0, key_ready}, 64'd1);
        build(k, dec);
        key_in    = k;
        decrypt   = dec;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom};
        decrypt   = ~dec;
    endtask

    initial begin
        logic [63:0] kr;
        logic        dr;
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, key_ready}, 64'd1);
        chk("rst_valid", {63'd0, subkey_valid}, 64'd0);
        chk("rst_last", {63'd0, last_round}, 64'd0);
        chk("rst_perr", {63'd0, parity_err}, 64'd0);
        chk("rst_subkey", {16'd0, subkey}, 64'd0);
        chk("rst_idx", {60'd0, round_idx}, 64'd0);
        rst_n = 1'b1;

        start(kat_key, 1'b0);
        drain(100, -1);
        chk("kat_enc_k1", {16'd0, cap_first}, 64'h1B02EFFC7072);
        chk("kat_enc_k16", {16'd0, cap_last}, 64'hCB3D8B0E17F5);
        chk("kat_perr", {63'd0, parity_err}, 64'd0);

        start(kat_key, 1'b1);
        drain(100, -1);
        chk("kat_dec_first", {16'd0, cap_first}, 64'hCB3D8B0E17F5);
        chk("kat_dec_last", {16'd0, cap_last}, 64'h1B02EFFC7072);

        start(kat_key, 1'b0);
        drain(30, -1);

        start(64'h0, 1'b0);
        drain(100, -1);
        chk("zero_perr", {63'd0, parity_err}, 64'd1);
        start(64'h0101010101010101, 1'b1);
        drain(60, -1);
        chk("odd_perr", {63'd0, parity_err}, 64'd0);

        // Back-to-back keys with key_valid never dropping.
        @(negedge clk);
        build(kat_key, 1'b0);
        key_in    = kat_key;
        decrypt   = 1'b0;
        key_valid = 1'b1;
        @(negedge clk);
        key_in = 64'hFEDCBA9876543210;
        drain(100, -1);
        @(posedge clk);
        #1 key_valid = 1'b0;
        build(64'hFEDCBA9876543210, 1'b0);
        @(negedge clk);
        drain(100, -1);

        // Asynchronous reset in the middle of a sequence.
        start(kat_key, 1'b1);
        drain(100, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, subkey_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, key_ready}, 64'd1);
        chk("mid_rst_subkey", {16'd0, subkey}, 64'd0);
        @(negedge clk);
        subkey_ready = 1'b0;
        rst_n = 1'b1;
        start(kat_key, 1'b0);
        drain(100, -1);

        for (int n = 0; n < 6; n++) begin
            kr = {$urandom, $urandom};
            dr = 1'($urandom_range(1));
            start(kr, dr);
            drain((n % 2 == 0) ? 30 : 100, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
